// File: rtl/ws2812_frame_scheduler_if.sv
// rtl/ws2812_frame_scheduler_if.sv - colour register read port and pixel stream to the WS2812 encoder
interface ws2812_frame_scheduler_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] color_addr;
    logic [23:0]       color_data;
    logic [23:0]       px_data;
    logic              px_valid;
    logic              px_ready;
    logic              enc_idle;

    modport master (
        output color_addr,
        input  color_data,
        output px_data,
        output px_valid,
        input  px_ready,
        input  enc_idle
    );

    modport slave (
        input  color_addr,
        output color_data,
        input  px_data,
        input  px_valid,
        output px_ready,
        output enc_idle
    );
endinterface

// File: rtl/ws2812_frame_scheduler.sv
// rtl/ws2812_frame_scheduler.sv - WS2812 frame sequencer (pixel walk, drain, latch gap); WS2812_SCHED_GRB_EN selects GRB pixel order
module ws2812_frame_scheduler #(
    parameter int NUM_LEDS     = 12,
    parameter int LATCH_CYCLES = 6000,
    parameter int AUTO_PERIOD  = 1666667
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        auto_en,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    ws2812_frame_scheduler_if.master px
);
    localparam int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int IDX_W  = $clog2(NUM_LEDS + 1);
    localparam int LAT_W  = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int TMR_W  = $clog2(AUTO_PERIOD);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, PRESENT, DRAIN, LATCH, DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [LAT_W-1:0]  latch_cnt;
    logic [TMR_W-1:0]  timer;
    logic              pending;
    logic              auto_tc;
    logic              request;

    // Register file holds {R,G,B}; the optional build reorders to the WS2812 wire order.
    function automatic logic [23:0] pixel_order(input logic [23:0] c);
`ifdef WS2812_SCHED_GRB_EN
        return {c[15:8], c[23:16], c[7:0]};
`else
        return c;
`endif
    endfunction

    assign auto_tc = auto_en && (timer == TMR_W'(AUTO_PERIOD - 1));
    assign request = start | auto_tc;

    // Free-running auto-refresh timer, held at zero while auto refresh is off.
    always_ff @(posedge clock) begin
        if (reset || !auto_en || auto_tc) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Single pending flag: requests during a frame coalesce into one follow-on frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (state == IDLE && pending) begin
            pending <= request;
        end else if (request) begin
            pending <= 1'b1;
        end
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            latch_cnt     <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_count   <= 16'd0;
            px.color_addr <= '0;
            px.px_data    <= 24'd0;
            px.px_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        state         <= FETCH;
                        busy          <= 1'b1;
                        idx           <= '0;
                        px.color_addr <= '0;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    px.px_data  <= pixel_order(px.color_data);
                    px.px_valid <= 1'b1;
                    state       <= PRESENT;
                end
                PRESENT: begin
                    if (px.px_ready) begin
                        px.px_valid <= 1'b0;
                        idx         <= idx + IDX_W'(1);
                        if (idx == IDX_W'(NUM_LEDS - 1)) begin
                            state <= DRAIN;
                        end else begin
                            px.color_addr <= ADDR_W'(idx + IDX_W'(1));
                            state         <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (px.enc_idle) begin
                        latch_cnt <= '0;
                        state     <= LATCH;
                    end
                end
                LATCH: begin
                    if (latch_cnt == LAT_W'(LATCH_CYCLES - 1)) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        state       <= DONE;
                    end else begin
                        latch_cnt <= latch_cnt + LAT_W'(1);
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// tb/tb_ws2812_frame_scheduler.sv - randomized and directed bench for ws2812_frame_scheduler against an event-time model
module tb_ws2812_frame_scheduler;
    localparam int NUM = 12;
    localparam int LAT = 8;
    localparam int PER = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        auto_en;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [23:0] mem [NUM];

    ws2812_frame_scheduler_if #(.ADDR_W(4)) pif ();

    ws2812_frame_scheduler #(
        .NUM_LEDS(NUM), .LATCH_CYCLES(LAT), .AUTO_PERIOD(PER)
    ) dut (
        .clock(clk), .reset(rst), .start(start), .auto_en(auto_en),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .px(pif)
    );

    always #5 clk = ~clk;

    // Registered colour register file: data follows the address by one clock.
    always @(posedge clk) pif.color_data <= mem[pif.color_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] wire_order(input logic [23:0] c);
`ifdef WS2812_SCHED_GRB_EN
        return {c[15:8], c[23:16], c[7:0]};
`else
        return c;
`endif
    endfunction

    // Model: frame progress kept as edge timestamps rather than states.
    int e = 0;
    int m_run, m_idx, m_offer, m_drain, m_done, m_idle_ok;
    bit m_pend, m_active, m_valid;
    logic [15:0] m_cnt;
    logic [3:0]  m_addr;
    logic [23:0] m_pxd;

    // Observation log
    bit o_valid, o_busy, o_done;
    logic [3:0] o_addr;
    int hs_cnt, last_hs_edge, low_run, last_gap;
    int addr_log[$];
    int done_edges[$];

    task automatic model_step(input bit s_rst, input bit s_start, input bit s_auto,
                              input bit s_rdy, input bit s_idle);
        bit tc;
        bit req;
        if (s_rst) begin
            m_pend = 0; m_run = 0; m_active = 0; m_idx = 0; m_offer = 0;
            m_drain = -1; m_done = -1; m_idle_ok = e + 1;
            m_cnt = 0; m_addr = 0; m_pxd = 0;
        end else begin
            tc = 0;
            if (s_auto) begin
                m_run++;
                if (m_run % PER == 0) tc = 1;
            end else begin
                m_run = 0;
            end
            req = s_start | tc;
            if (!m_active && e >= m_idle_ok && m_pend) begin
                m_active = 1; m_idx = 0; m_offer = e + 2;
                m_drain = -1; m_done = -1; m_addr = 0;
                m_pend = req;
            end else begin
                m_pend = m_pend | req;
                if (m_active) begin
                    if (m_drain < 0) begin
                        if (e > m_offer && s_rdy) begin
                            m_idx++;
                            if (m_idx < NUM) begin
                                m_offer = e + 2;
                                m_addr = 4'(m_idx);
                            end else begin
                                m_drain = e;
                            end
                        end
                    end else if (m_done < 0) begin
                        if (s_idle) m_done = e + LAT;
                    end else if (e == m_done) begin
                        m_cnt = m_cnt + 16'd1;
                    end else if (e == m_done + 1) begin
                        m_active = 0;
                        m_idle_ok = e + 1;
                    end
                end
            end
        end
        m_valid = m_active && m_drain < 0 && e >= m_offer;
        if (m_valid) m_pxd = wire_order(mem[m_idx]);
    endtask

    task automatic cyc();
        bit s_rst, s_start, s_auto, s_rdy, s_idle;
        @(posedge clk);
        s_rst = rst; s_start = start; s_auto = auto_en;
        s_rdy = pif.px_ready; s_idle = pif.enc_idle;
        e++;
        if (!s_rst && o_valid && s_rdy) begin
            hs_cnt++;
            addr_log.push_back(int'(o_addr));
            last_hs_edge = e;
        end
        model_step(s_rst, s_start, s_auto, s_rdy, s_idle);
        #1;
        o_valid = pif.px_valid; o_busy = busy; o_done = frame_done; o_addr = pif.color_addr;
        if (o_done) done_edges.push_back(e);
        if (!o_busy) begin
            low_run++;
        end else begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end
        check("busy", busy, m_active);
        check("px_valid", pif.px_valid, m_valid);
        check("frame_done", frame_done, m_active && m_done >= 0 && e == m_done);
        check("frame_count", frame_count, m_cnt);
        check("color_addr", pif.color_addr, m_addr);
        check("px_data", pif.px_data, m_pxd);
    endtask

    task automatic clear_log();
        hs_cnt = 0; addr_log.delete(); done_edges.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!o_done && k < budget);
        check("done_timeout", o_done, 1);
    endtask

    initial begin
        logic [23:0] held;
        logic [23:0] grb_exp;
        logic [15:0] cnt0;
        int k;
        rst = 1'b1; start = 1'b0; auto_en = 1'b0;
        pif.px_ready = 1'b0; pif.enc_idle = 1'b0;
        for (int i = 0; i < NUM; i++) mem[i] = 24'h010203 + 24'(i);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Single frame, no backpressure
        pif.px_ready = 1'b1; pif.enc_idle = 1'b1;
        clear_log();
        pulse_start();
        wait_done(300);
        check("hs_count", hs_cnt, NUM);
        for (int i = 0; i < NUM; i++) check("addr_order", addr_log.size() > i ? addr_log[i] : -1, i);
        check("done_latency", done_edges.size() > 0 ? done_edges[0] - last_hs_edge : 0, LAT + 1);
        check("frame_count_1", frame_count, 1);
        repeat (5) cyc();

        // Backpressure on pixel 3
        clear_log();
        pulse_start();
        k = 0;
        while (!(m_valid && m_idx == 3) && k < 300) begin cyc(); k++; end
        check("bp_reach_timeout", m_valid && m_idx == 3, 1);
        pif.px_ready = 1'b0;
        held = pif.px_data;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_valid_hold", pif.px_valid, 1);
            check("bp_data_hold", pif.px_data, held);
        end
        pif.px_ready = 1'b1;
        wait_done(300);
        check("bp_hs_count", hs_cnt, NUM);

        // Coalescing: three starts during LATCH give one extra frame
        repeat (5) cyc();
        clear_log();
        cnt0 = frame_count;
        pulse_start();
        k = 0;
        while (m_done < 0 && k < 300) begin cyc(); k++; end
        check("latch_reach_timeout", m_done >= 0, 1);
        for (int i = 0; i < 3; i++) begin pulse_start(); cyc(); end
        wait_done(300);
        wait_done(300);
        repeat (60) cyc();
        check("coalesce_frames", done_edges.size(), 2);
        check("coalesce_gap", last_gap, 1);
        check("coalesce_count", frame_count - cnt0, 2);

        // Auto refresh
        clear_log();
        auto_en = 1'b1;
        repeat (1000) cyc();
        auto_en = 1'b0;
        repeat (150) cyc();
        check("auto_frames", done_edges.size(), 10);
        for (int i = 1; i < 10 && i < done_edges.size(); i++)
            check("auto_spacing", done_edges[i] - done_edges[i-1], PER);

        // Reset while pixel 6 is presented
        pulse_start();
        k = 0;
        while (!(m_valid && m_idx == 6) && k < 300) begin cyc(); k++; end
        check("px6_reach_timeout", m_valid && m_idx == 6, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_px_valid", pif.px_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_count", frame_count, 0);
        pulse_start();
        k = 0;
        while (!o_busy && k < 10) begin cyc(); k++; end
        check("restart_busy", o_busy, 1);
        check("restart_addr", pif.color_addr, 0);
        wait_done(300);

        // Pixel wire order
        repeat (3) cyc();
        mem[0] = 24'hAABBCC;
`ifdef WS2812_SCHED_GRB_EN
        grb_exp = 24'hBBAACC;
`else
        grb_exp = 24'hAABBCC;
`endif
        pulse_start();
        k = 0;
        while (!o_valid && k < 10) begin cyc(); k++; end
        check("order_valid", o_valid, 1);
        check("order_px_data", pif.px_data, grb_exp);
        wait_done(300);

        // Randomized traffic
        repeat (3) cyc();
        for (int i = 0; i < NUM; i++) mem[i] = 24'($urandom);
        for (int i = 0; i < 4000; i++) begin
            pif.px_ready = ($urandom % 4) != 0;
            pif.enc_idle = ($urandom % 3) == 0;
            start = ($urandom % 60) == 0;
            if (($urandom % 300) == 0) auto_en = ~auto_en;
            rst = ($urandom % 700) == 0;
            cyc();
        end
        rst = 1'b0; start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
